// File: rtl/coproc_pkg.sv
// Shared matrix-coprocessor constants and lane addressing helpers.
//   ELEM_W : width of one signed element / scalar
//   N_ELEM : elements per packed row vector
//   VEC_W  : packed row vector width
package coproc_pkg;

    localparam int unsigned ELEM_W = 8;
    localparam int unsigned N_ELEM = 5;
    localparam int unsigned VEC_W  = N_ELEM * ELEM_W;
    localparam int unsigned PROD_W = 2 * ELEM_W;

    // Element 0 sits in the most significant lane of the packed vector.
    function automatic int unsigned lane_lsb(input int unsigned idx);
        return (N_ELEM - 1 - idx) * ELEM_W;
    endfunction

endpackage : coproc_pkg

// File: rtl/mult_lane.sv
// One signed lane multiplier: ELEM_W x ELEM_W signed, wrapped to ELEM_W bits.
//   a      : signed element
//   b      : signed scalar
//   prod_c : low ELEM_W bits of the full product (combinational)
//   ovf_c  : full product does not fit in ELEM_W signed bits (combinational)
module mult_lane
    import coproc_pkg::*;
(
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    output logic [ELEM_W-1:0] prod_c,
    output logic              ovf_c
);

    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    logic signed [PROD_W-1:0] full;
    logic        [ELEM_W:0]   top_bits;

    // Sign-extend both operands so the PROD_W-bit product is exact.
    assign a_ext = {{ELEM_W{a[ELEM_W-1]}}, a};
    assign b_ext = {{ELEM_W{b[ELEM_W-1]}}, b};
    assign full  = a_ext * b_ext;

    assign prod_c = full[ELEM_W-1:0];

    // Product fits only if every bit from the result sign bit upward agrees.
    assign top_bits = full[PROD_W-1:ELEM_W-1];
    assign ovf_c    = !((&top_bits) || !(|top_bits));

endmodule : mult_lane

// File: rtl/mult_mi.sv
// Matrix-row by scalar multiply: N_ELEM parallel signed lanes, wrapped
// products and a combined overflow flag, registered with 1-cycle latency.
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   in_valid  : capture m_1 / n this cycle
//   m_1       : packed signed row, element 0 in the top lane
//   n         : signed scalar
//   m_out     : packed wrapped products, same lane order as m_1
//   ovf       : any lane product left the signed ELEM_W range
//   out_valid : m_out / ovf were refreshed on the last edge
module mult_mi
    import coproc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [VEC_W-1:0]  m_1,
    input  logic [ELEM_W-1:0] n,
    output logic [VEC_W-1:0]  m_out,
    output logic              ovf,
    output logic              out_valid
);

    logic [VEC_W-1:0]  prod_vec;
    logic [N_ELEM-1:0] lane_ovf;

    logic [VEC_W-1:0]  m_out_d,     m_out_q;
    logic              ovf_d,       ovf_q;
    logic              out_valid_d, out_valid_q;

    // Parallel lane multipliers.
    for (genvar i = 0; i < N_ELEM; i++) begin : g_lane
        localparam int unsigned LSB = lane_lsb(i);
        mult_lane u_lane (
            .a      (m_1[LSB +: ELEM_W]),
            .b      (n),
            .prod_c (prod_vec[LSB +: ELEM_W]),
            .ovf_c  (lane_ovf[i])
        );
    end

    // Next-state: load on in_valid, otherwise hold data and drop valid.
    always_comb begin
        m_out_d     = m_out_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            m_out_d     = prod_vec;
            ovf_d       = |lane_ovf;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_out_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            m_out_q     <= m_out_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign m_out     = m_out_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule : mult_mi

// File: tb/tb_mult_mi.sv
// Self-checking bench for mult_mi: directed literal cases plus randomized
// traffic compared every cycle against an integer-arithmetic model.
module tb_mult_mi;

    localparam int unsigned EW = 8;
    localparam int unsigned NE = 5;
    localparam int unsigned VW = NE * EW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [VW-1:0] m_1 = '0;
    logic [EW-1:0] n = '0;
    logic [VW-1:0] m_out;
    logic          ovf;
    logic          out_valid;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model state: what the outputs must show after the latest edge.
    logic [VW-1:0] mdl_m = '0;
    logic          mdl_o = 1'b0;
    logic          mdl_v = 1'b0;

    mult_mi dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .m_1       (m_1),
        .n         (n),
        .m_out     (m_out),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Plain integer arithmetic per element.
    function automatic void model(input logic [VW-1:0] m, input logic [EW-1:0] s,
                                  output logic [VW-1:0] r, output logic o);
        int a, b, p;
        logic [EW-1:0] e;
        r = '0;
        o = 1'b0;
        b = int'($signed(s));
        for (int i = 0; i < NE; i++) begin
            e = m[(NE-1-i)*EW +: EW];
            a = int'($signed(e));
            p = a * b;
            r[(NE-1-i)*EW +: EW] = EW'(p);
            if (p > 127 || p < -128) o = 1'b1;
        end
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mdl_m = '0;
            mdl_o = 1'b0;
            mdl_v = 1'b0;
        end else if (in_valid) begin
            model(m_1, n, mdl_m, mdl_o);
            mdl_v = 1'b1;
        end else begin
            mdl_v = 1'b0;
        end
    end

    task automatic check(input string name, input logic [VW+1:0] got, input logic [VW+1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got m_out=%h ovf=%b vld=%b, want m_out=%h ovf=%b vld=%b",
                     name, got[VW+1:2], got[1], got[0], exp[VW+1:2], exp[1], exp[0]);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) check("model", {m_out, ovf, out_valid}, {mdl_m, mdl_o, mdl_v});
    end

    task automatic drive(input logic v, input logic [VW-1:0] m, input logic [EW-1:0] s);
        @(posedge clk);
        #2;
        in_valid = v;
        m_1      = m;
        n        = s;
    endtask

    task automatic one_shot(input string name, input logic [VW-1:0] m, input logic [EW-1:0] s,
                            input logic [VW-1:0] exp_m, input logic exp_o);
        drive(1'b1, m, s);
        drive(1'b0, m, s);
        @(negedge clk);
        #1;
        check(name, {m_out, ovf, out_valid}, {exp_m, exp_o, 1'b1});
    endtask

    function automatic logic [EW-1:0] rnd_byte();
        case ($urandom_range(0, 5))
            0:       return 8'h80;
            1:       return 8'h7F;
            2:       return 8'hFF;
            3:       return 8'h00;
            default: return EW'($urandom);
        endcase
    endfunction

    initial begin
        logic [VW-1:0] rv;
        #1 rst = 1'b0;
        #1;
        check("reset_lit", {m_out, ovf, out_valid}, '0);
        @(negedge clk);
        #1 rst = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("idle_after_reset", {m_out, ovf, out_valid}, '0);

        one_shot("pos_no_ovf", 40'h0203040500, 8'd3,  40'h06090C0F00, 1'b0);
        one_shot("mixed_sign", 40'h02FD04FB00, 8'hFD, 40'hFA09F40F00, 1'b0);
        one_shot("ovf_wrap",   40'h0A0B0C0D00, 8'd11, 40'h6E79848F00, 1'b1);
        one_shot("neg1_edge",  40'h80807F0100, 8'hFF, 40'h808081FF00, 1'b1);
        one_shot("pos1_edge",  40'h80807F0100, 8'h01, 40'h80807F0100, 1'b0);
        one_shot("times_zero", 40'h80807F0100, 8'h00, 40'h0000000000, 1'b0);

        // Back-to-back: one result per edge, then hold with valid low.
        drive(1'b1, 40'h0203040500, 8'd3);
        @(negedge clk);
        drive(1'b1, 40'h02FD04FB00, 8'hFD);
        @(negedge clk); #1;
        check("b2b_0", {m_out, ovf, out_valid}, {40'h06090C0F00, 1'b0, 1'b1});
        drive(1'b1, 40'h0A0B0C0D00, 8'd11);
        @(negedge clk); #1;
        check("b2b_1", {m_out, ovf, out_valid}, {40'hFA09F40F00, 1'b0, 1'b1});
        drive(1'b0, '0, '0);
        @(negedge clk); #1;
        check("b2b_2", {m_out, ovf, out_valid}, {40'h6E79848F00, 1'b1, 1'b1});
        @(negedge clk); #1;
        check("hold", {m_out, ovf, out_valid}, {40'h6E79848F00, 1'b1, 1'b0});

        // Asynchronous reset mid-cycle while a result is held.
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("async_reset", {m_out, ovf, out_valid}, '0);
        @(negedge clk);
        #1 rst = 1'b1;

        // Randomized traffic, with occasional mid-stream resets.
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < NE; i++) rv[(NE-1-i)*EW +: EW] = rnd_byte();
            if ($urandom_range(0, 7) == 0) rv[EW-1:0] = '0;
            drive(($urandom_range(0, 3) != 0), rv, rnd_byte());
            if (k % 150 == 77) begin
                #1 rst = 1'b0;
                @(negedge clk);
                #1 rst = 1'b1;
            end
        end
        drive(1'b0, '0, '0);
        repeat (2) @(negedge clk);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_mult_mi

// File: doc/mult_mi.md
Name: mult_mi

Overview:
- Multiplies a packed vector of signed 8-bit elements (one matrix row, 5 elements) by one signed 8-bit scalar.
- Produces the wrapped 8-bit per-lane products and a single overflow flag.
- It is the scalar-multiply (matrix × integer) datapath of the matrix coprocessor ALU.
- Output is registered, with 1-cycle latency.

Parameters:
- N_ELEM, 5, number of elements per packed vector.
- ELEM_W, 8, width of each signed element and of the scalar (two's complement).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  qualifies m_1 and n for capture this cycle.
- m_1  input  N_ELEM*ELEM_W (40)  packed signed operand vector; element 0 at [39:32], element 4 at [7:0].
- n  input  ELEM_W (8)  signed scalar multiplier.
- m_out  output  N_ELEM*ELEM_W (40)  packed products, same lane order as m_1.
- ovf  output  1  set when any lane product falls outside [-128, 127].
- out_valid  output  1  m_out/ovf hold a fresh result.

Behaviour:
- Reset (rst low, asynchronous assert, synchronous-to-clk release): m_out = 0, ovf = 0, out_valid = 0. Reset held low mid-operation discards the pending result.
- Per lane i:
  - full product p_i = signed(m_1 lane i) × signed(n), computed at 16 bits.
  - m_out lane i = p_i[7:0]. The result wraps; it does not saturate.
- Lane overflow occurs when p_i > 127 or p_i < -128, i.e. p_i[15:7] is not all equal.
- ovf = OR of all lane overflows.
- All lanes are computed in parallel in the same cycle.
- Latency:
  - in_valid high at edge k → m_out/ovf/out_valid updated at edge k+1.
  - out_valid is high for exactly that cycle unless in_valid is high again.
- in_valid low: m_out and ovf hold their last values; out_valid = 0.
- Back-to-back in_valid: one result per cycle, full throughput, no stall.
- Corner cases:
  - -128 × -1 = +128 → lane = 0x80, ovf = 1.
  - -128 × 1 → 0x80, ovf = 0.
  - × 0 → 0, ovf = 0.
- A zero element (e.g. the unused 5th lane) always yields 0 with no overflow.
- No X propagation: outputs are defined from reset onward.

Decomposition:
- Shared package (coproc_pkg): ELEM_W, N_ELEM, VEC_W = N_ELEM*ELEM_W, and a lane slice helper or index constant. These are shared with the add/sub/transpose blocks.
- One natural sub-module, mult_lane: combinational signed 8×8 → 8-bit wrapped product plus lane overflow bit. It is instantiated N_ELEM times via generate. mult_mi holds the output registers and the OR-reduction.

Test Plan:
- Reset: rst low asynchronously mid-cycle → m_out = 0, ovf = 0, out_valid = 0 immediately. Release, then no in_valid → outputs stay 0.
- Positive, no overflow:
  - Stimulus: m_1 = [2,3,4,5,0] (0x0203040500), n = 3, in_valid pulse.
  - Next edge: m_out = [6,9,12,15,0] = 0x06090C0F00, ovf = 0, out_valid = 1.
- Mixed signs:
  - Stimulus: m_1 = [2,-3,4,-5,0] (0x02FD04FB00), n = -3 (0xFD).
  - Response: m_out = [-6,9,-12,15,0] = 0xFA09F40F00, ovf = 0.
- Overflow with wrap:
  - Stimulus: m_1 = [10,11,12,13,0] (0x0A0B0C0D00), n = 11.
  - Response: m_out = 0x6E79848F00 (110, 121, 132→0x84, 143→0x8F, 0), ovf = 1.
- Boundary cases:
  - m_1 = [-128,-128,127,1,0], n = -1 → m_out = [0x80,0x80,0x81,0xFF,0x00], ovf = 1.
  - Same m_1 with n = 1 → m_out = 0x80807F0100, ovf = 0.
- Throughput/hold:
  - Stimulus: three consecutive in_valid cycles with the cases above.
  - Response: results appear on three consecutive edges, one cycle delayed. After in_valid drops, the last m_out/ovf hold and out_valid = 0.
